// File: rtl/csa_resolve_seq.sv
// Sequential carry-save resolver: turns a (sum, carry) pair into a plain binary result,
// propagating carries BLOCK_SIZE bits per clock, LSB block first.
module csa_resolve_seq #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned BLOCK_SIZE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_z,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [1:0]       out_hi,
  output logic             busy
);

  localparam int unsigned NBLK = WIDTH / BLOCK_SIZE;
  localparam int unsigned CntW = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int unsigned SumW = BLOCK_SIZE + 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [1:0]       hi_q, hi_d;
  logic             bc_q, bc_d;
  logic             top_q, top_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [SumW-1:0]  blk_sum;
  logic [WIDTH-1:0] blk_ext;

  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    c_d     = c_q;
    res_d   = res_q;
    hi_d    = hi_q;
    bc_d    = bc_q;
    top_d   = top_q;
    cnt_d   = cnt_q;

    blk_sum = SumW'(z_q[BLOCK_SIZE-1:0]) + SumW'(c_q[BLOCK_SIZE-1:0]) + SumW'(bc_q);
    blk_ext = WIDTH'(blk_sum[BLOCK_SIZE-1:0]);

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          z_d     = in_z;
          // Carry vector is pre-aligned to weight 2^i; its MSB falls off and is kept apart.
          c_d     = in_carry << 1;
          top_d   = in_carry[WIDTH-1];
          bc_d    = 1'b0;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        res_d = (res_q >> BLOCK_SIZE) | (blk_ext << (WIDTH - BLOCK_SIZE));
        bc_d  = blk_sum[BLOCK_SIZE];
        z_d   = z_q >> BLOCK_SIZE;
        c_d   = c_q >> BLOCK_SIZE;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(NBLK - 1)) begin
          hi_d    = 2'(blk_sum[BLOCK_SIZE]) + 2'(top_q);
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      z_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      bc_q    <= 1'b0;
      top_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      c_q     <= c_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      bc_q    <= bc_d;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StBusy);
  assign out_valid = (state_q == StDone);
  assign out_res   = res_q;
  assign out_hi    = hi_q;

endmodule

// File: tb/tb_csa_resolve_seq.sv
// Directed bench for csa_resolve_seq (WIDTH=8, BLOCK_SIZE=4) with a queue scoreboard
// holding in_z + 2*in_carry for every accepted pair.
module tb_csa_resolve_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_z;
  logic [7:0] in_carry;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_res;
  logic [1:0] out_hi;
  logic       busy;

  typedef struct packed {
    logic [1:0] hi;
    logic [7:0] res;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  csa_resolve_seq #(
    .WIDTH      (8),
    .BLOCK_SIZE (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_z      (in_z),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_hi    (out_hi),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] z, input logic [7:0] c);
    logic [9:0] s;
    s = {2'b00, z} + {1'b0, c, 1'b0};
    return exp_t'(s);
  endfunction

  // Compare the current output against the oldest scoreboard entry.
  task automatic pop_check(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_res"}, 32'(out_res), 32'(e.res));
      check({tag, "_hi"}, 32'(out_hi), 32'(e.hi));
    end
  endtask

  // Present one pair from a negedge in IDLE; returns at the negedge after the handshake.
  task automatic send(input logic [7:0] z, input logic [7:0] c);
    in_valid = 1'b1;
    in_z     = z;
    in_carry = c;
    check("send_in_ready", 32'(in_ready), 32'd1);
    sb.push_back(model(z, c));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; returns number of posedges seen since the handshake edge.
  task automatic wait_valid(output int k);
    k = 0;
    while (!out_valid && k < 12) begin
      @(negedge clk);
      k++;
    end
    check("wait_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic run_one(input string tag, input logic [7:0] z, input logic [7:0] c);
    int k;
    out_ready = 1'b1;
    send(z, c);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_valid(k);
    check({tag, "_latency"}, 32'(k), 32'd2);
    pop_check(tag);
    @(negedge clk);
    check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int   k;
    exp_t held;
    int   sent, rcvd, last_acc, cyc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_z      = '0;
    in_carry  = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_res", 32'(out_res), 32'd0);
    check("rst_out_hi", 32'(out_hi), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_one("t0f_01", 8'h0F, 8'h01);
    run_one("tff_ff", 8'hFF, 8'hFF);
    run_one("tfe_01", 8'hFE, 8'h01);
    run_one("t0f_08", 8'h0F, 8'h08);

    // Backpressure: result must hold and new data must be refused while DONE.
    out_ready = 1'b0;
    send(8'h5A, 8'h33);
    wait_valid(k);
    held      = sb[0];
    in_valid  = 1'b1;
    in_z      = 8'hAA;
    in_carry  = 8'h55;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_res_stable", 32'(out_res), 32'(held.res));
      check("bp_hi_stable", 32'(out_hi), 32'(held.hi));
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    pop_check("bp");
    @(negedge clk);
    check("bp_after_valid", 32'(out_valid), 32'd0);
    check("bp_after_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("bp_not_accepted", 32'(busy), 32'd0);

    // Reset during the first BUSY cycle discards the operation.
    send(8'h0F, 8'h01);
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_res", 32'(out_res), 32'd0);
    check("mid_rst_hi", 32'(out_hi), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    run_one("post_rst", 8'h0F, 8'h01);

    // Back-to-back stream with in_valid and out_ready held high.
    sent      = 0;
    rcvd      = 0;
    last_acc  = -1;
    cyc       = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_z      = 8'($urandom);
    in_carry  = 8'($urandom);
    while (rcvd < 20 && cyc < 400) begin
      if (out_valid) begin
        pop_check("stream");
        rcvd++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(in_z, in_carry));
        if (last_acc >= 0) check("stream_spacing", 32'(cyc - last_acc), 32'd4);
        last_acc = cyc;
        sent++;
        @(negedge clk);
        cyc++;
        if (sent < 20) begin
          in_z     = 8'($urandom);
          in_carry = 8'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("stream_received", 32'(rcvd), 32'd20);
    check("stream_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
